// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit lookahead segment per stage,
// registered inter-segment carry, operand skew/deskew and a global valid/ready advance.
module cla_pipe_addsub #(
    parameter int unsigned N   = 64,
    parameter int unsigned SEG = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned L = N / SEG;

    // Returns {carry into segment msb, carry out, sum}.
    function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                              input logic c0);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           prop;
        logic           ci;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < int'(SEG); i++) begin
            prop = 1'b1;
            ci   = g[i];
            for (int j = i - 1; j >= 0; j--) begin
                prop = prop & p[j+1];
                ci   = ci | (prop & g[j]);
            end
            prop   = prop & p[0];
            c[i+1] = ci | (prop & c0);
        end
        return {c[SEG-1], c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic [N-1:0] a_q   [L];
    logic [N-1:0] b_q   [L];
    logic [N-1:0] s_q   [L];
    logic         c_q   [L];
    logic         sub_q [L];
    logic         v_q   [L];
    logic [N-1:0] a_d   [L];
    logic [N-1:0] b_d   [L];
    logic [N-1:0] s_d   [L];
    logic         c_d   [L];
    logic         sub_d [L];
    logic         v_d   [L];
    logic         ovf_q, ovf_d;
    logic         zero_q, zero_d;

    logic [N-1:0]   a_in, b_in, s_in;
    logic           c_in, sub_in, v_in;
    logic [SEG+1:0] seg_r;
    logic           adv;

    assign adv       = ~v_q[L-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[L-1];
    assign sum       = s_q[L-1];
    assign cout      = c_q[L-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    always_comb begin
        a_in   = '0;
        b_in   = '0;
        s_in   = '0;
        c_in   = 1'b0;
        sub_in = 1'b0;
        v_in   = 1'b0;
        seg_r  = '0;
        for (int k = 0; k < int'(L); k++) begin
            if (k == 0) begin
                a_in   = A;
                b_in   = B;
                s_in   = '0;
                c_in   = sub | cin;
                sub_in = sub;
                v_in   = in_valid;
            end else begin
                a_in   = a_q[(k > 0) ? k - 1 : 0];
                b_in   = b_q[(k > 0) ? k - 1 : 0];
                s_in   = s_q[(k > 0) ? k - 1 : 0];
                c_in   = c_q[(k > 0) ? k - 1 : 0];
                sub_in = sub_q[(k > 0) ? k - 1 : 0];
                v_in   = v_q[(k > 0) ? k - 1 : 0];
            end
            seg_r = cla_seg(a_in[k*SEG +: SEG], b_in[k*SEG +: SEG] ^ {SEG{sub_in}}, c_in);
            a_d[k]              = a_in;
            b_d[k]              = b_in;
            sub_d[k]            = sub_in;
            v_d[k]              = v_in;
            c_d[k]              = seg_r[SEG];
            s_d[k]              = s_in;
            s_d[k][k*SEG +: SEG] = seg_r[SEG-1:0];
        end
        // seg_r now holds the final segment's result.
        ovf_d  = seg_r[SEG+1] ^ seg_r[SEG];
        zero_d = (s_d[L-1] == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(L); k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                v_q[k]   <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < int'(L); k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                sub_q[k] <= sub_d[k];
                v_q[k]   <= v_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    // Consumed operand segments and the final stage's operand copies are never read.
    logic unused_ops;
    always_comb begin
        unused_ops = 1'b0;
        for (int k = 0; k < int'(L); k++) begin
            unused_ops = unused_ops ^ (^{a_q[k], b_q[k], sub_q[k]});
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: three configurations (8/4, 64/16, 16/16) checked against an
// arithmetic reference model, hand vectors, backpressure streaming and mid-flight reset.
module tb_cla_pipe_addsub;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ov;
        logic       z;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        out_ready;
    logic [63:0] a_s, b_s;
    logic        cin_s, sub_s;
    logic        iv8, iv64, iv16;
    logic        ir8, ir64, ir16;
    logic        ov8, ov64, ov16;
    logic [7:0]  sum8;
    logic [63:0] sum64;
    logic [15:0] sum16;
    logic        co8, co64, co16, of8, of64, of16, z8, z64, z16;

    int total = 0;
    int bad   = 0;

    cla_pipe_addsub #(.N(8), .SEG(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a_s[7:0]), .B(b_s[7:0]),
        .cin(cin_s), .sub(sub_s), .out_valid(ov8), .out_ready(out_ready), .sum(sum8),
        .cout(co8), .ovf(of8), .zero(z8)
    );

    cla_pipe_addsub #(.N(64), .SEG(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .A(a_s), .B(b_s),
        .cin(cin_s), .sub(sub_s), .out_valid(ov64), .out_ready(out_ready), .sum(sum64),
        .cout(co64), .ovf(of64), .zero(z64)
    );

    cla_pipe_addsub #(.N(16), .SEG(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a_s[15:0]), .B(b_s[15:0]),
        .cin(cin_s), .sub(sub_s), .out_valid(ov16), .out_ready(out_ready), .sum(sum16),
        .cout(co16), .ovf(of16), .zero(z16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Plain modular arithmetic on an n-bit word.
    function automatic res_t ref_op(input int n, input logic [63:0] a, input logic [63:0] b,
                                    input logic cin, input logic sub);
        logic [64:0] mask, tot;
        logic [63:0] aa, bb;
        res_t r;
        mask   = (65'd1 << n) - 65'd1;
        aa     = a & mask[63:0];
        bb     = (sub ? ~b : b) & mask[63:0];
        tot    = {1'b0, aa} + {1'b0, bb} + (sub ? 65'd1 : {64'd0, cin});
        r.sum  = tot[63:0] & mask[63:0];
        r.cout = tot[n];
        r.ovf  = (aa[n-1] == bb[n-1]) && (r.sum[n-1] != aa[n-1]);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iv(input int which, input logic v);
        iv8  = (which == 0) && v;
        iv64 = (which == 1) && v;
        iv16 = (which == 2) && v;
    endtask

    task automatic get_out(input int which, output logic v, output res_t r);
        case (which)
            0: begin v = ov8;  r.sum = {56'd0, sum8};  r.cout = co8;  r.ovf = of8;  r.zero = z8;  end
            1: begin v = ov64; r.sum = sum64;          r.cout = co64; r.ovf = of64; r.zero = z64; end
            default: begin
                v = ov16; r.sum = {48'd0, sum16}; r.cout = co16; r.ovf = of16; r.zero = z16;
            end
        endcase
    endtask

    // Single op with out_ready high; checks the exact latency and all result fields.
    task automatic run_op(input int which, input logic [63:0] a, input logic [63:0] b,
                          input logic ci, input logic sb, input res_t exp, input string nm);
        int   lat;
        logic v;
        res_t r;
        lat       = (which == 0) ? 2 : (which == 1) ? 4 : 1;
        a_s       = a;
        b_s       = b;
        cin_s     = ci;
        sub_s     = sb;
        out_ready = 1'b1;
        set_iv(which, 1'b1);
        tick();
        set_iv(which, 1'b0);
        for (int i = 1; i < lat; i++) begin
            get_out(which, v, r);
            chk({nm, "_early"}, 64'(v), 64'd0);
            tick();
        end
        get_out(which, v, r);
        chk({nm, "_valid"}, 64'(v), 64'd1);
        chk({nm, "_sum"}, r.sum, exp.sum);
        chk({nm, "_flags"}, {61'd0, r.cout, r.ovf, r.zero}, {61'd0, exp.cout, exp.ovf, exp.zero});
    endtask

    // Stream ops through the 8-bit instance; rnd=0 stalls cycles 3..5 after the first result.
    task automatic stream(input int nops, input bit rnd, input string nm);
        logic [10:0] q[$];
        logic [10:0] held, exp_w;
        res_t        m;
        int          issued, got, since, cyc;
        logic        stalled;
        logic [7:0]  ca, cb;
        logic        cc, cs;
        issued = 0;
        got    = 0;
        since  = -1;
        cyc    = 0;
        ca = 8'($urandom); cb = 8'($urandom); cc = 1'($urandom); cs = 1'($urandom);
        while (got < nops && cyc < 4000) begin
            if (since >= 0) since++;
            if (since < 0 && ov8) since = 0;
            iv8       = (issued < nops) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            a_s       = {56'd0, ca};
            b_s       = {56'd0, cb};
            cin_s     = cc;
            sub_s     = cs;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(since >= 3 && since <= 5);
            #1;
            stalled = ov8 && !out_ready;
            held    = {of8, z8, co8, sum8};
            if (stalled) chk({nm, "_stall_in_ready"}, 64'(ir8), 64'd0);
            if (ov8 && out_ready) begin
                if (q.size() == 0) begin
                    chk({nm, "_extra_result"}, 64'(held), 64'h7ff);
                end else begin
                    exp_w = q.pop_front();
                    chk({nm, "_result"}, 64'(held), 64'(exp_w));
                end
                got++;
            end
            if (iv8 && ir8) begin
                m = ref_op(8, {56'd0, ca}, {56'd0, cb}, cc, cs);
                q.push_back({m.ovf, m.zero, m.cout, m.sum[7:0]});
                issued++;
                ca = 8'($urandom); cb = 8'($urandom); cc = 1'($urandom); cs = 1'($urandom);
            end
            @(posedge clk);
            #1;
            if (stalled) chk({nm, "_stall_hold"}, {52'd0, ov8, of8, z8, co8, sum8},
                             {52'd0, 1'b1, held});
            cyc++;
        end
        iv8 = 1'b0;
        chk({nm, "_count"}, 64'(got), 64'(nops));
        chk({nm, "_leftover"}, 64'(q.size()), 64'd0);
    endtask

    vec_t tbl[7];
    res_t e;
    int   seen;
    logic [63:0] ra, rb;
    logic        rc, rs;

    initial begin
        tbl[0] = '{a: 8'h7f, b: 8'h01, cin: 1'b0, sub: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1, z: 1'b0};
        tbl[1] = '{a: 8'hff, b: 8'h00, cin: 1'b1, sub: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0, z: 1'b1};
        tbl[2] = '{a: 8'h05, b: 8'h07, cin: 1'b0, sub: 1'b1, s: 8'hfe, co: 1'b0, ov: 1'b0, z: 1'b0};
        tbl[3] = '{a: 8'h80, b: 8'h01, cin: 1'b0, sub: 1'b1, s: 8'h7f, co: 1'b1, ov: 1'b1, z: 1'b0};
        tbl[4] = '{a: 8'h33, b: 8'h44, cin: 1'b1, sub: 1'b0, s: 8'h78, co: 1'b0, ov: 1'b0, z: 1'b0};
        tbl[5] = '{a: 8'h42, b: 8'h42, cin: 1'b1, sub: 1'b1, s: 8'h00, co: 1'b1, ov: 1'b0, z: 1'b1};
        tbl[6] = '{a: 8'h88, b: 8'h88, cin: 1'b0, sub: 1'b0, s: 8'h10, co: 1'b1, ov: 1'b1, z: 1'b0};

        rst = 1'b1; out_ready = 1'b1; a_s = '0; b_s = '0; cin_s = 1'b0; sub_s = 1'b0;
        iv8 = 1'b0; iv64 = 1'b0; iv16 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset8",  {52'd0, ov8, ir8, co8, of8, z8, sum8}, {52'd0, 1'b0, 1'b1, 3'b000, 8'h00});
        chk("reset64_ctl", {59'd0, ov64, ir64, co64, of64, z64}, {59'd0, 5'b01000});
        chk("reset64_sum", sum64, 64'd0);
        chk("reset16", {44'd0, ov16, ir16, co16, of16, z16, sum16}, {44'd0, 5'b01000, 16'h0});

        for (int i = 0; i < 7; i++) begin
            e.sum = {56'd0, tbl[i].s}; e.cout = tbl[i].co; e.ovf = tbl[i].ov; e.zero = tbl[i].z;
            run_op(0, {56'd0, tbl[i].a}, {56'd0, tbl[i].b}, tbl[i].cin, tbl[i].sub, e,
                   $sformatf("vec8_%0d", i));
        end

        run_op(1, 64'd5, 64'd7, 1'b1, 1'b1, '{sum: 64'hffff_ffff_ffff_fffe, cout: 1'b0,
               ovf: 1'b0, zero: 1'b0}, "sub64_neg");
        run_op(1, 64'd7, 64'd5, 1'b0, 1'b1, '{sum: 64'd2, cout: 1'b1, ovf: 1'b0, zero: 1'b0},
               "sub64_pos");
        run_op(2, 64'h8000, 64'h8000, 1'b0, 1'b0, '{sum: 64'd0, cout: 1'b1, ovf: 1'b1,
               zero: 1'b1}, "deg16");

        for (int i = 0; i < 30; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            rc = 1'($urandom); rs = 1'($urandom);
            if (i < 3) rb = ~ra;
            run_op(1, ra, rb, rc, rs, ref_op(64, ra, rb, rc, rs), $sformatf("rnd64_%0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            ra = 64'($urandom_range(0, 65535)); rb = 64'($urandom_range(0, 65535));
            rc = 1'($urandom); rs = 1'($urandom);
            run_op(2, ra, rb, rc, rs, ref_op(16, ra, rb, rc, rs), $sformatf("rnd16_%0d", i));
        end

        out_ready = 1'b1;
        tick();
        stream(8, 1'b0, "bp8");
        out_ready = 1'b1;
        tick();
        stream(200, 1'b1, "rnd8");

        // Reset with two ops in flight in the 4-stage instance.
        out_ready = 1'b1;
        tick();
        a_s = 64'd1; b_s = 64'd2; cin_s = 1'b0; sub_s = 1'b0; iv64 = 1'b1;
        tick();
        a_s = 64'd3;
        tick();
        rst = 1'b1; a_s = 64'h55;
        tick();
        rst = 1'b0; iv64 = 1'b0;
        chk("rst_clear", {sum64[59:0], ov64, co64, of64, z64}, 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ov64) seen++;
        end
        chk("rst_discard", 64'(seen), 64'd0);
        run_op(1, 64'h10, 64'h20, 1'b0, 1'b0, '{sum: 64'h30, cout: 1'b0, ovf: 1'b0, zero: 1'b0},
               "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor for wide operands.
- The N-bit operation is split into N/SEG segments. Each segment is a SEG-bit lookahead adder, and the inter-segment carry is registered between stages.
- Operands enter through a valid/ready handshake and results leave through one, so the block sits between datapath producers and consumers that may stall.
- Adds subtract mode, signed-overflow and zero flags, and backpressure.

Parameters:
- N, 64, operand width in bits; must be a multiple of SEG.
- SEG, 16, segment width (bits resolved per pipeline stage); 1 <= SEG <= N.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands A, B, cin, sub are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- A  input  N  first operand.
- B  input  N  second operand.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1), cin ignored.
- out_valid  output  1  result fields valid.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  N  result bits.
- cout  output  1  carry out of bit N-1 (for sub=1, cout=1 means no borrow).
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Stage count and latency:
  - L = N/SEG stages.
  - An accepted operation appears on out_valid exactly L cycles after the accept edge when no stall occurs.
  - With SEG=N, L=1.
- Stage k (0..L-1):
  - Computes segment bits [k*SEG +: SEG] with a SEG-bit lookahead adder.
  - Carry-in is the effective cin for k=0, otherwise the registered carry of stage k-1 for the same operation.
  - B is inverted per segment when the operation's sub bit is set.
- Operand skew and deskew:
  - Unconsumed upper segments of A and B (and the sub bit) travel with the operation through the stage registers.
  - Completed lower sum segments also travel forward, so all fields of one operation emerge together.
- Effective carry-in = sub ? 1 : cin.
- Flags, computed on the final segment:
  - ovf = carry into bit N-1 XOR carry out of bit N-1.
  - zero = (sum == 0).
- Flow control:
  - Global advance signal adv = ~out_valid | out_ready.
  - When adv=1, every stage register loads from its predecessor. Stage 0 loads the input and its valid bit is set to in_valid.
  - When adv=0, all stage registers hold.
  - in_ready = adv. This is combinational from out_ready and is documented as such; consumers must not derive out_ready from in_ready.
  - Accept occurs on in_valid & in_ready. Result transfer occurs on out_valid & out_ready.
- Bubbles:
  - Valid bits move with the data.
  - An invalid stage still advances when adv=1, so bubbles fill and drain naturally.
  - Throughput is 1 op/cycle when out_ready is held high.
- Stall behaviour: while out_valid=1 & out_ready=0, the outputs sum, cout, ovf, zero and out_valid remain stable, and no accepted operation is lost or duplicated.
- Output register values:
  - When out_valid=0, the output data values are don't-care for the consumer.
  - The implementation nevertheless holds the last register contents.
- Reset:
  - rst=1 clears every stage valid bit and every data/flag register to 0 on the next edge.
  - After that edge: out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 while rst is low after the reset edge.
  - Operations in flight during reset are discarded; no output is produced for them.
  - Operands presented in the reset cycle are not accepted.
- Arithmetic is modulo 2^N: wrap-around is reported only via cout and ovf, never saturated.

Test Plan:
- Basic add, N=8 SEG=4 (L=2):
  - Stimulus: A=0x7F, B=0x01, cin=0, sub=0, one cycle, out_ready=1.
  - Required: out_valid exactly 2 cycles later with sum=0x80, cout=0, ovf=1, zero=0.
- Inter-segment carry, N=8 SEG=4:
  - Stimulus: A=0xFF, B=0x00, cin=1.
  - Required: sum=0x00, cout=1, ovf=0, zero=1; confirms the carry crosses the stage boundary.
- Subtract, N=64 SEG=16:
  - Stimulus 1: A=5, B=7, sub=1, cin=1 (ignored). Required: sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - Stimulus 2: A=7, B=5, sub=1. Required: sum=2, cout=1.
- Streaming with backpressure, N=8 SEG=4:
  - Stimulus: 8 back-to-back random ops; out_ready low for cycles 3-5 after the first result.
  - Required: outputs hold stable while stalled, in_ready=0 during the stall, all 8 results match the reference model in order, none lost or duplicated.
- Reset mid-operation:
  - Stimulus: issue 2 ops, assert rst for 1 cycle before either completes.
  - Required: out_valid stays 0 and no result for those ops ever appears. After reset, a new op A=0x10, B=0x20 yields sum=0x30 at latency L.
- Degenerate SEG=N=16 (L=1):
  - Stimulus: A=0x8000, B=0x8000, sub=0.
  - Required: one cycle later sum=0x0000, cout=1, ovf=1, zero=1.
